uart_tx_arbiter: RTL and testbench

Shares the single byte-wide UART transmitter among NUM_REQ requesters, such as key dump, ciphertext dump and debug readout. Arbitration is round-robin with packet locking: a grant is held until the owner's byte flagged "last" has been fully sent. The block drives the transmitter's transmit/data/clear handshake and sits between the readout controllers and the transmitter instance.

---
 rtl/uart_arb_pkg.sv | 8 +
 rtl/rr_select.sv | 23 ++
 rtl/uart_tx_arbiter.sv | 75 +++++++
 tb/tb_uart_tx_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: arbiter state encoding, ASCII bytes shared with readout controllers, index-width helper
package uart_arb_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_CLR, HOLD} state_t;
  localparam logic [7:0] ONE = 8'h31, ZERO = 8'h30, SPACE = 8'h20, UNDERLINE = 8'h5F;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_select.sv
// rr_select: round-robin picker starting at ptr; in req/ptr, out one-hot win, win_idx, any_req
module rr_select import uart_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IW = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [IW-1:0]      win_idx,
  output logic               any_req
);
  logic [IW-1:0] j;
  always_comb begin
    win_idx = '0;
    j = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % NUM_REQ);
      if (req[j]) win_idx = j;
    end
  end
  assign any_req = |req;
  assign win = any_req ? NUM_REQ'(1) << win_idx : '0;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin share of one UART tx; in req/req_data/req_last/tx_clear, out req_ack/grant/busy/lock_timeout/tx_transmit/tx_data
module uart_tx_arbiter import uart_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int DATAWIDTH = 8,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  output logic                         lock_timeout,
  output logic                         tx_transmit,
  output logic [DATAWIDTH-1:0]         tx_data,
  input  logic                         tx_clear
);
  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);
  state_t state, state_n;
  logic [IW-1:0] ptr, owner, win_idx;
  logic [NUM_REQ-1:0] win;
  logic [CW-1:0] cnt;
  logic any_req, own_req, hold_last, tout, rel;
  rr_select #(.NUM_REQ(NUM_REQ), .IW(IW)) u_sel (
    .req(req), .ptr(ptr), .win(win), .win_idx(win_idx), .any_req(any_req)
  );
  assign own_req = req[owner];
  assign tout = (HOLD_TIMEOUT != 0) && state == HOLD && !own_req && cnt == CNT_LAST;
  assign rel = (state == WAIT_CLR && !tx_clear && hold_last) || tout;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = any_req ? LOAD : IDLE;
      LOAD:     state_n = own_req ? SEND : HOLD;
      SEND:     state_n = tx_clear ? WAIT_CLR : SEND;
      WAIT_CLR: state_n = tx_clear ? WAIT_CLR : hold_last ? IDLE : own_req ? LOAD : HOLD;
      HOLD:     state_n = own_req ? LOAD : tout ? IDLE : HOLD;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      grant <= '0;
      cnt <= '0;
      tx_data <= '0;
      hold_last <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (state != HOLD) ? '0 : (&cnt) ? cnt : cnt + 1'b1;
      if (state == IDLE && any_req) begin
        owner <= win_idx;
        grant <= win;
      end
      if (rel) begin
        grant <= '0;
        ptr <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
      end
      if (state == LOAD && own_req) begin
        tx_data <= req_data[owner*DATAWIDTH +: DATAWIDTH];
        hold_last <= req_last[owner];
      end
    end
  end
  assign busy = state != IDLE;
  assign tx_transmit = state == SEND;
  assign lock_timeout = tout;
  assign req_ack = (state == LOAD && own_req) ? grant : '0;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with requester and transmitter models
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;
  localparam int N = 4, W = 8, TO = 16;
  logic clk = 1'b0, rst = 1'b0;
  logic [N-1:0] req = '0, req_last = '0, req_ack, grant;
  logic [N*W-1:0] req_data = '0;
  logic busy, lock_timeout, tx_transmit, tx_clear;
  logic stale = 1'b0, mclr = 1'b0, tx_prev = 1'b0;
  logic [W-1:0] tx_data;
  logic [N-1:0] ack_s = '0;
  int n_cmp = 0, n_bad = 0, cyc = 0, clr_falls = 0, clr_fall_cyc = 0, n_tout = 0, tcnt = 0;
  int ack_cnt [N];
  logic [W:0] q [N][$];
  logic [N+W-1:0] exp_q [$];
  assign tx_clear = stale | mclr;
  always #5 clk = ~clk;
  uart_tx_arbiter #(.NUM_REQ(N), .DATAWIDTH(W), .HOLD_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack), .grant(grant), .busy(busy), .lock_timeout(lock_timeout),
    .tx_transmit(tx_transmit), .tx_data(tx_data), .tx_clear(tx_clear)
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask
  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += q[i].size();
    return s;
  endfunction
  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0 || pending() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < 2000), 1);
  endtask
  always @(posedge clk) cyc++;
  always @(negedge clk) ack_s = req_ack;
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (ack_s[i] && q[i].size() > 0) void'(q[i].pop_front());
      req[i] = q[i].size() > 0;
      {req_last[i], req_data[i*W +: W]} = req[i] ? q[i][0] : '0;
    end
  end
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mclr = 1'b0;
      tcnt = 0;
    end else begin
      #1;
      if (mclr) begin
        mclr = 1'b0;
        clr_falls++;
        clr_fall_cyc = cyc;
      end else if (tx_transmit) begin
        if (tcnt == 9) begin
          mclr = 1'b1;
          tcnt = 0;
        end else tcnt++;
      end else tcnt = 0;
    end
  end
  always @(negedge clk) begin
    logic [N+W-1:0] e;
    if (tx_transmit && !tx_prev) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL tx_unexpected: grant=%b data=%h with empty scoreboard", grant, tx_data);
      end else begin
        e = exp_q.pop_front();
        chk("tx_grant", 32'(grant), 32'(e[N+W-1:W]));
        chk("tx_data", 32'(tx_data), 32'(e[W-1:0]));
      end
    end
    tx_prev = tx_transmit;
    if (req_ack != '0) begin
      chk("ack_onehot", $countones(req_ack), 1);
      chk("ack_is_owner", 32'(req_ack), 32'(grant));
      for (int i = 0; i < N; i++) ack_cnt[i] += int'(req_ack[i]);
    end
    if (lock_timeout) begin
      n_tout++;
      chk("timeout_delay", cyc - clr_fall_cyc, 16);
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
  initial begin
    int n, f0, a0, a1, t0;
    logic bad;
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({grant, req_ack, busy, lock_timeout, tx_transmit, tx_data}), 0);
    rst = 1'b1;
    @(negedge clk);
    stale = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      bad = bad | busy | tx_transmit | (|req_ack);
    end
    chk("stale_clear_idle", 32'(bad), 0);
    stale = 1'b0;
    @(negedge clk);
    f0 = clr_falls;
    a0 = ack_cnt[0];
    q[0].push_back({1'b0, ONE});
    q[0].push_back({1'b0, ZERO});
    q[0].push_back({1'b1, SPACE});
    exp_q.push_back({4'b0001, ONE});
    exp_q.push_back({4'b0001, ZERO});
    exp_q.push_back({4'b0001, SPACE});
    n = 0;
    while (clr_falls < f0 + 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t1_clear_falls", clr_falls - f0, 3);
    chk("t1_grant_hold", 32'(grant), 32'(4'b0001));
    @(negedge clk);
    chk("t1_grant_after", 32'(grant), 0);
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_acks", ack_cnt[0] - a0, 3);
    f0 = clr_falls;
    a0 = ack_cnt[0];
    a1 = ack_cnt[1];
    q[0].push_back({1'b0, 8'h41});
    q[0].push_back({1'b1, 8'h42});
    exp_q.push_back({4'b0001, 8'h41});
    exp_q.push_back({4'b0001, 8'h42});
    exp_q.push_back({4'b0010, 8'h51});
    repeat (3) @(negedge clk);
    q[1].push_back({1'b1, 8'h51});
    n = 0;
    while (!grant[1] && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t3_owner0_acks", ack_cnt[0] - a0, 2);
    chk("t3_owner0_done", clr_falls - f0, 2);
    chk("t3_req1_no_early_ack", ack_cnt[1] - a1, 0);
    wait_idle("t3_idle");
    rst = 1'b0;
    q[0].push_back({1'b1, 8'hA0});
    q[0].push_back({1'b1, 8'hA4});
    for (int i = 1; i < N; i++) q[i].push_back({1'b1, 8'(8'hA0 + i)});
    exp_q.push_back({4'b0001, 8'hA0});
    exp_q.push_back({4'b0010, 8'hA1});
    exp_q.push_back({4'b0100, 8'hA2});
    exp_q.push_back({4'b1000, 8'hA3});
    exp_q.push_back({4'b0001, 8'hA4});
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_idle("t2_idle");
    t0 = n_tout;
    q[0].push_back({1'b0, 8'h60});
    exp_q.push_back({4'b0001, 8'h60});
    exp_q.push_back({4'b0010, 8'h61});
    repeat (3) @(negedge clk);
    q[1].push_back({1'b1, 8'h61});
    n = 0;
    while (!lock_timeout && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t4_timeout_seen", 32'(lock_timeout), 1);
    repeat (2) @(negedge clk);
    chk("t4_grant_after", 32'(grant), 32'(4'b0010));
    wait_idle("t4_idle");
    chk("t4_timeout_count", n_tout - t0, 1);
    q[0].push_back({1'b1, 8'h70});
    exp_q.push_back({4'b0001, 8'h70});
    n = 0;
    while (!tx_transmit && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_in_send", 32'(tx_transmit), 1);
    #1 rst = 1'b0;
    #1;
    chk("t5_async_tx", 32'(tx_transmit), 0);
    chk("t5_async_grant", 32'(grant), 0);
    chk("t5_async_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) q[i].push_back({1'b1, 8'(8'h80 + i)});
    exp_q.push_back({4'b0001, 8'h80});
    exp_q.push_back({4'b0010, 8'h81});
    exp_q.push_back({4'b0100, 8'h82});
    exp_q.push_back({4'b1000, 8'h83});
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_idle("t5_idle");
    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
